// File: rtl/game_countdown.sv
// game_countdown: BCD seconds countdown with IDLE/RUN/DONE control.
// Optional low-time warning output enabled by defining COUNTDOWN_WARN_EN.
module game_countdown #(
    parameter logic [3:0] DEFAULT_TENS = 4'd6,
    parameter logic [3:0] DEFAULT_ONES = 4'd0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] startTens,
    input  logic [3:0] startOnes,
    input  logic       start,
    input  logic       abort,
    input  logic       oneSecTimeout,
    output logic       timerEnable,
    output logic [3:0] secTens,
    output logic [3:0] secOnes,
    output logic       timeUp,
`ifdef COUNTDOWN_WARN_EN
    output logic       warn,
`endif
    output logic       done
);

    localparam int unsigned DIGIT_W = 4;
    localparam int unsigned STATE_W = 2;

    localparam logic [STATE_W-1:0] ST_IDLE = 2'd0;
    localparam logic [STATE_W-1:0] ST_RUN  = 2'd1;
    localparam logic [STATE_W-1:0] ST_DONE = 2'd2;

    logic [STATE_W-1:0] state;
    logic [STATE_W-1:0] state_n;
    logic [DIGIT_W-1:0] tens_n;
    logic [DIGIT_W-1:0] ones_n;
    logic [DIGIT_W-1:0] rel_tens;
    logic [DIGIT_W-1:0] rel_ones;
    logic [DIGIT_W-1:0] rel_tens_n;
    logic [DIGIT_W-1:0] rel_ones_n;
    logic               time_up_n;
    logic               count_zero;
    logic               count_one;

    // Saturate a loaded digit to the largest legal BCD value.
    function automatic logic [DIGIT_W-1:0] clamp_digit(input logic [DIGIT_W-1:0] d);
        return (d > DIGIT_W'(9)) ? DIGIT_W'(9) : d;
    endfunction

    assign count_zero = (secTens == '0) && (secOnes == '0);
    assign count_one  = (secTens == '0) && (secOnes == DIGIT_W'(1));

    // Upstream timer runs only while counting.
    assign timerEnable = (state == ST_RUN);

    // Next-state, next-count and pulse decode.
    always_comb begin
        state_n    = state;
        tens_n     = secTens;
        ones_n     = secOnes;
        rel_tens_n = rel_tens;
        rel_ones_n = rel_ones;
        time_up_n  = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (load) begin
                    tens_n     = clamp_digit(startTens);
                    ones_n     = clamp_digit(startOnes);
                    rel_tens_n = clamp_digit(startTens);
                    rel_ones_n = clamp_digit(startOnes);
                    state_n    = ST_IDLE;
                end else if (start) begin
                    if (state == ST_DONE) begin
                        tens_n  = rel_tens;
                        ones_n  = rel_ones;
                        state_n = ST_RUN;
                    end else if (!count_zero) begin
                        state_n = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_n = ST_IDLE;
                end else if (oneSecTimeout) begin
                    if (count_one) begin
                        tens_n    = '0;
                        ones_n    = '0;
                        state_n   = ST_DONE;
                        time_up_n = 1'b1;
                    end else if (secOnes != '0) begin
                        ones_n = secOnes - DIGIT_W'(1);
                    end else begin
                        ones_n = DIGIT_W'(9);
                        tens_n = secTens - DIGIT_W'(1);
                    end
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // State, count, reload and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            secTens  <= DEFAULT_TENS;
            secOnes  <= DEFAULT_ONES;
            rel_tens <= DEFAULT_TENS;
            rel_ones <= DEFAULT_ONES;
            timeUp   <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_n;
            secTens  <= tens_n;
            secOnes  <= ones_n;
            rel_tens <= rel_tens_n;
            rel_ones <= rel_ones_n;
            timeUp   <= time_up_n;
            done     <= (state_n == ST_DONE);
        end
    end

`ifdef COUNTDOWN_WARN_EN
    // Warning tracks RUN with ten seconds or fewer remaining.
    always_ff @(posedge clk) begin
        if (rst) begin
            warn <= 1'b0;
        end else begin
            warn <= (state_n == ST_RUN) &&
                    ((tens_n == '0) || ((tens_n == DIGIT_W'(1)) && (ones_n == '0)));
        end
    end
`endif

endmodule

// File: tb/tb_game_countdown.sv
// tb_game_countdown: directed plus randomized checks against a seconds-level model.
module tb_game_countdown;

    logic       clk = 1'b0;
    logic       rst;
    logic       load;
    logic [3:0] startTens;
    logic [3:0] startOnes;
    logic       start;
    logic       abort;
    logic       oneSecTimeout;
    logic       timerEnable;
    logic [3:0] secTens;
    logic [3:0] secOnes;
    logic       timeUp;
    logic       done;
`ifdef COUNTDOWN_WARN_EN
    logic       warn;
`endif

    int n_vec = 0;
    int n_err = 0;

    // Model: count in whole seconds, mode 0=idle 1=run 2=done.
    int m_cnt  = 60;
    int m_rel  = 60;
    int m_mode = 0;
    int m_tu   = 0;

    game_countdown dut (
        .clk(clk),
        .rst(rst),
        .load(load),
        .startTens(startTens),
        .startOnes(startOnes),
        .start(start),
        .abort(abort),
        .oneSecTimeout(oneSecTimeout),
        .timerEnable(timerEnable),
        .secTens(secTens),
        .secOnes(secOnes),
        .timeUp(timeUp),
`ifdef COUNTDOWN_WARN_EN
        .warn(warn),
`endif
        .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int min9(input int d);
        return (d > 9) ? 9 : d;
    endfunction

    // Advance the model by one clock using the applied inputs.
    task automatic model_step(input bit r, input bit l, input int lt, input int lo,
                              input bit s, input bit a, input bit t);
        m_tu = 0;
        if (r) begin
            m_mode = 0;
            m_cnt  = 60;
            m_rel  = 60;
        end else if (m_mode == 1) begin
            if (a) begin
                m_mode = 0;
            end else if (t) begin
                m_cnt = m_cnt - 1;
                if (m_cnt == 0) begin
                    m_mode = 2;
                    m_tu   = 1;
                end
            end
        end else begin
            if (l) begin
                m_cnt  = min9(lt) * 10 + min9(lo);
                m_rel  = m_cnt;
                m_mode = 0;
            end else if (s && m_mode == 2) begin
                m_cnt  = m_rel;
                m_mode = 1;
            end else if (s && m_cnt != 0) begin
                m_mode = 1;
            end
        end
    endtask

    // Drive one cycle of inputs, clock, then compare every output to the model.
    task automatic cycle(input bit r, input bit l, input logic [3:0] lt, input logic [3:0] lo,
                         input bit s, input bit a, input bit t);
        rst = r; load = l; startTens = lt; startOnes = lo;
        start = s; abort = a; oneSecTimeout = t;
        @(posedge clk);
        #1;
        model_step(r, l, int'(lt), int'(lo), s, a, t);
        check("secTens", int'(secTens), m_cnt / 10);
        check("secOnes", int'(secOnes), m_cnt % 10);
        check("timerEnable", int'(timerEnable), int'(m_mode == 1));
        check("done", int'(done), int'(m_mode == 2));
        check("timeUp", int'(timeUp), m_tu);
`ifdef COUNTDOWN_WARN_EN
        check("warn", int'(warn), int'(m_mode == 1 && m_cnt <= 10));
`endif
    endtask

    task automatic nop();
        cycle(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic go();
        cycle(1'b0, 1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic ld(input logic [3:0] lt, input logic [3:0] lo);
        cycle(1'b0, 1'b1, lt, lo, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic halt();
        cycle(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        rst = 1'b1; load = 1'b0; startTens = 4'd0; startOnes = 4'd0;
        start = 1'b0; abort = 1'b0; oneSecTimeout = 1'b0;

        // Reset and full 60-second run from the default.
        cycle(1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        check("rst_tens", int'(secTens), 6);
        check("rst_ones", int'(secOnes), 0);
        check("rst_te", int'(timerEnable), 0);
        go();
        check("run_te", int'(timerEnable), 1);
        tick(1);
        check("cnt59", int'(secTens) * 10 + int'(secOnes), 59);
        tick(59);
        check("exp60_tu", int'(timeUp), 1);
        check("exp60_done", int'(done), 1);
        check("exp60_te", int'(timerEnable), 0);
        nop();
        check("tu_pulse", int'(timeUp), 0);

        // Borrow across digits.
        ld(4'd1, 4'd0);
        go();
        tick(1);
        check("cnt09", int'(secTens) * 10 + int'(secOnes), 9);
        tick(9);
        check("exp10_tu", int'(timeUp), 1);

        // Abort holds, ticks ignored in idle, resume.
        ld(4'd0, 4'd3);
        go();
        tick(1);
        halt();
        check("abort_te", int'(timerEnable), 0);
        tick(3);
        check("hold02", int'(secTens) * 10 + int'(secOnes), 2);
        go();
        tick(2);
        check("resume_tu", int'(timeUp), 1);

        // Clamp, load beats start, abort beats tick.
        ld(4'd12, 4'd15);
        check("clamp99", int'(secTens) * 10 + int'(secOnes), 99);
        cycle(1'b0, 1'b1, 4'd0, 4'd5, 1'b1, 1'b0, 1'b0);
        check("load_wins", int'(timerEnable), 0);
        go();
        cycle(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b1);
        check("abort_wins", int'(secTens) * 10 + int'(secOnes), 5);

        // Restart from DONE reloads, then reset mid-run at 37.
        go();
        tick(5);
        go();
        check("reload05", int'(secTens) * 10 + int'(secOnes), 5);
        check("reload_te", int'(timerEnable), 1);
        halt();
        ld(4'd4, 4'd0);
        go();
        tick(3);
        check("cnt37", int'(secTens) * 10 + int'(secOnes), 37);
        cycle(1'b1, 1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b1);
        check("midrst_cnt", int'(secTens) * 10 + int'(secOnes), 60);
        check("midrst_te", int'(timerEnable), 0);

`ifdef COUNTDOWN_WARN_EN
        ld(4'd1, 4'd2);
        go();
        tick(1);
        check("warn11", int'(warn), 0);
        tick(1);
        check("warn10", int'(warn), 1);
        halt();
        check("warn_abort", int'(warn), 0);
`endif

        // Randomized traffic; short loads keep expiries frequent.
        for (int i = 0; i < 3000; i++) begin
            logic [3:0] lt;
            logic [3:0] lo;
            if ($urandom_range(0, 7) == 0) lt = 4'($urandom_range(0, 15));
            else                           lt = 4'($urandom_range(0, 1));
            lo = 4'($urandom_range(0, 15));
            cycle($urandom_range(0, 299) == 0,
                  $urandom_range(0, 24) == 0,
                  lt, lo,
                  $urandom_range(0, 5) == 0,
                  $urandom_range(0, 39) == 0,
                  $urandom_range(0, 1) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/game_countdown.md
GAME_COUNTDOWN -- requirements
Module: game_countdown

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, using the codebase port names clk and rst.
REQ-002 Parameter DEFAULT_TENS, default 6, SHALL be the BCD tens digit of the count and reload value at reset.
REQ-003 Parameter DEFAULT_ONES, default 0, SHALL be the BCD ones digit of the count and reload value at reset.
REQ-004 Port clk  in  1  SHALL be the system clock; all state changes on its rising edge.
REQ-005 Port rst  in  1  SHALL be the synchronous active-high reset.
REQ-006 Port load  in  1  SHALL request capture of startTens/startOnes.
REQ-007 Port startTens  in  4  SHALL carry the BCD tens digit to load.
REQ-008 Port startOnes  in  4  SHALL carry the BCD ones digit to load.
REQ-009 Port start  in  1  SHALL request that counting begins.
REQ-010 Port abort  in  1  SHALL request that counting stops, holding the count.
REQ-011 Port oneSecTimeout  in  1  SHALL be the one-cycle, once-per-second tick from the upstream one-second timer.
REQ-012 Port timerEnable  out  1  SHALL drive the upstream one-second timer enable.
REQ-013 Port secTens  out  4  SHALL be the remaining-seconds BCD tens digit.
REQ-014 Port secOnes  out  4  SHALL be the remaining-seconds BCD ones digit.
REQ-015 Port timeUp  out  1  SHALL be a one-cycle pulse on expiry.
REQ-016 Port done  out  1  SHALL be a level, high while in state DONE.
REQ-017 Port warn  out  1  SHALL be the low-time warning, present only with the macro defined (REQ-036).

Function
REQ-018 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-019 timerEnable SHALL be a combinational decode of state, high only in RUN, so it drops in the same cycle the FSM leaves RUN.
REQ-020 In IDLE or DONE, load SHALL write the clamped digits into both the count and the reload register, and the next state SHALL be IDLE; clamping maps any digit greater than 9 to 9.
REQ-021 load SHALL be ignored in RUN.
REQ-022 In IDLE, start with a nonzero count SHALL move to RUN on the next edge; start with count 00 SHALL be ignored.
REQ-023 If load and start are high in the same cycle, load SHALL win and start SHALL be ignored.
REQ-024 In RUN, each oneSecTimeout SHALL decrement the count by 1 second in BCD: if ones > 0, ones-1; otherwise ones becomes 9 and tens-1.
REQ-025 Each decrement SHALL be visible on secTens/secOnes one cycle after the tick (the registered edge).
REQ-026 The decrement from 01 to 00 SHALL, on the same edge, set the count to 00, enter DONE and assert timeUp for exactly one cycle.
REQ-027 oneSecTimeout SHALL be ignored in IDLE and DONE; the count never wraps below 00.
REQ-028 In RUN, abort SHALL return to IDLE and hold the current count, so a later start resumes from it; abort outside RUN SHALL be ignored.
REQ-029 If abort and oneSecTimeout are high in the same RUN cycle, abort SHALL win and no decrement occurs.
REQ-030 In DONE, start SHALL copy the reload register into the count and enter RUN; load is handled per REQ-020.
REQ-031 done SHALL be high exactly while in DONE.

Reset
REQ-032 rst SHALL set state to IDLE and count and reload to DEFAULT_TENS:DEFAULT_ONES.
REQ-033 rst SHALL set timerEnable, timeUp, done and warn to 0.
REQ-034 rst SHALL override all other inputs in the same cycle, including mid-RUN and on a timeUp cycle.

Configuration
REQ-035 Macro COUNTDOWN_WARN_EN SHALL control the warning feature.
REQ-036 With COUNTDOWN_WARN_EN defined, warn SHALL be registered and high while in RUN with count <= 10 (tens 0, or tens 1 and ones 0), and low otherwise.
REQ-037 With COUNTDOWN_WARN_EN undefined, the warn port and its logic SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-038 Reset, then start with parameters 6/0 -> RUN and timerEnable=1; after 1 tick the count is 59, and after 60 ticks it is 00 with timeUp high for 1 cycle, done=1 and timerEnable=0.
REQ-039 Load 1/0, start, 1 tick -> count 09 (borrow across digits); 9 more ticks -> timeUp and done.
REQ-040 Load 0/3, start, 1 tick, abort -> IDLE holding 02 with no timerEnable; 3 extra ticks in IDLE -> still 02; start plus 2 ticks -> 00 and timeUp.
REQ-041 Load with startTens=12 and startOnes=15 -> count 99; load and start in the same cycle -> IDLE with no RUN; abort and tick in the same cycle -> no decrement.
REQ-042 In DONE, start -> reload value restored and RUN; rst asserted mid-RUN at count 37 -> IDLE, count equals the default, all outputs 0.
REQ-043 With COUNTDOWN_WARN_EN defined, count 11 -> warn=0, next tick (10) -> warn=1, abort -> warn=0.
